pe_accum_f32: RTL and testbench

Sequential accumulation controller for the processing element, sitting directly upstream of the combinational `add_f32` adder. It accepts a stream of IEEE-754 single-precision values over a valid/ready handshake. It drives registered operands into the adder (running sum, new element) and captures the adder result back into the running sum. On the element flagged `in_last` it presents the total, element count and a sticky NaN flag on a valid/ready output port.

---
 rtl/pe_accum_f32.sv | 177 +++++++++++++++++
 tb/tb_pe_accum_f32.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_accum_f32.sv
// -----------------------------------------------------------------------------
// pe_accum_f32
//
// Sequential accumulation controller for one processing element. It sits
// directly upstream of a purely combinational single-precision adder
// (add_f32). Elements arrive over a valid/ready handshake. Each one is
// registered onto the adder operands together with the running sum, and the
// adder result is captured back into the running sum on the following edge.
// When the element flagged in_last has been folded in, the total, the element
// count and a sticky NaN flag are offered on a valid/ready result port.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      in_data / in_last valid
//   in_ready   out  1      element can be accepted this cycle
//   in_data    in   WIDTH  float element
//   in_last    in   1      element closes the current accumulation
//   add_a      out  WIDTH  adder operand a (registered running sum)
//   add_b      out  WIDTH  adder operand b (registered element)
//   add_sum    in   WIDTH  combinational add_f32(add_a, add_b)
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes the result
//   out_data   out  WIDTH  accumulated sum
//   out_count  out  CNT_W  elements accumulated (saturating)
//   out_nan    out  1      some intermediate add_sum was a NaN
//
// State table
//   ST_ACC | idle / waiting for the next element, in_ready = 1
//   ST_SUM | adder operands stable, capture add_sum into the running sum
//   ST_OUT | result presented, waiting for out_ready
// -----------------------------------------------------------------------------
module pe_accum_f32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan
);

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_SUM = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_add_a;
  logic [WIDTH-1:0]   r_add_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last;
  logic               r_nan;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_release;
  logic               w_sum_nan;
  logic               w_cnt_max;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // in_ready is gated by rst so it reads 0 during the reset cycle even when
  // the state register has not yet been forced back to ST_ACC.
  assign w_in_ready = (r_state == ST_ACC) && !rst;
  assign w_accept   = in_valid && w_in_ready;
  assign w_release  = (r_state == ST_OUT) && out_ready;

  // Any NaN encoding: exponent all ones with a non-zero mantissa.
  assign w_sum_nan  = (&add_sum[30:23]) && (|add_sum[22:0]);
  assign w_cnt_max  = &r_cnt;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ACC: begin
        if (w_accept) begin
          w_next = ST_SUM;
        end
      end
      ST_SUM: begin
        if (r_last) begin
          w_next = ST_OUT;
        end else begin
          w_next = ST_ACC;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          w_next = ST_ACC;
        end
      end
      default: begin
        w_next = ST_ACC;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand registers: loaded only on an accepted element so the adder inputs
  // stay stable through ST_SUM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_add_a <= '0;
      r_add_b <= '0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_add_a <= r_acc;
      r_add_b <= in_data;
      r_last  <= in_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Running sum, element counter and sticky NaN flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_nan <= 1'b0;
    end else if (r_state == ST_SUM) begin
      r_acc <= add_sum;
      if (!w_cnt_max) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_sum_nan) begin
        r_nan <= 1'b1;
      end
    end else if (w_release) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_nan <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = w_in_ready;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign out_valid = (r_state == ST_OUT);
  assign out_data  = r_acc;
  assign out_count = r_cnt;
  assign out_nan   = r_nan;

endmodule

// File: tb/tb_pe_accum_f32.sv
// -----------------------------------------------------------------------------
// tb_pe_accum_f32
//
// Directed bench for pe_accum_f32. A behavioural float adder closes the
// add_a/add_b -> add_sum loop. A second instance with a 2-bit counter shares
// the input stream so counter saturation can be observed on a short stream.
// -----------------------------------------------------------------------------
module tb_pe_accum_f32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_count;
  logic        out_nan;

  logic        in_ready2;
  logic [31:0] add_a2;
  logic [31:0] add_b2;
  logic [31:0] add_sum2;
  logic        out_valid2;
  logic [31:0] out_data2;
  logic [1:0]  out_count2;
  logic        out_nan2;

  int n_total = 0;
  int n_pass  = 0;
  int n_acc   = 0;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural adder: exact for the small values used here; any NaN or
  // infinity operand yields the adder's canonical NaN 7FFFFFFF.
  // ---------------------------------------------------------------------------
  function automatic real f2r(input logic [31:0] f);
    real v;
    int  e;
    if (f[30:23] == 8'h00) return 0.0;
    e = int'(f[30:23]) - 127;
    v = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** e);
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          ex;
    logic [31:0] ex_v;
    if (r == 0.0) return 32'h0000_0000;
    d    = $realtobits(r);
    ex   = int'(d[62:52]) - 1023 + 127;
    ex_v = ex;
    return {d[63], ex_v[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FFF_FFFF;
    return r2f(f2r(a) + f2r(b));
  endfunction

  always_comb add_sum  = f_add(add_a, add_b);
  always_comb add_sum2 = f_add(add_a2, add_b2);

  pe_accum_f32 #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_nan(out_nan)
  );

  pe_accum_f32 #(.WIDTH(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
    .add_a(add_a2), .add_b(add_b2), .add_sum(add_sum2),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_count(out_count2), .out_nan(out_nan2)
  );

  always @(posedge clk) begin
    if (in_valid && in_ready) n_acc++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, got, exp);
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int k;
    k        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge after the last element was accepted, out_ready = 1.
  task automatic expect_result(input string name, input logic [31:0] sum,
                               input logic [15:0] cnt, input logic nan);
    check({name, "_sum_state_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_sum_state_ready"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_data"},  out_data, sum);
    check({name, "_count"}, {16'd0, out_count}, {16'd0, cnt});
    check({name, "_nan"},   {31'd0, out_nan}, {31'd0, nan});
    @(negedge clk);
    check({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [31:0] elem [4];
    logic [31:0] sum;
    logic [15:0] cnt;
    logic        nan;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          acc0;
    logic [31:0] hold;

    vecs[0] = '{"basic",  2, '{32'h3F80_0000, 32'h4000_0000, 0, 0}, 32'h4040_0000, 16'd2, 1'b0};
    vecs[1] = '{"single", 1, '{32'h3F00_0000, 0, 0, 0},             32'h3F00_0000, 16'd1, 1'b0};
    vecs[2] = '{"cancel", 2, '{32'h3F80_0000, 32'hBF80_0000, 0, 0}, 32'h0000_0000, 16'd2, 1'b0};
    vecs[3] = '{"nan",    2, '{32'h7FC0_0000, 32'h3F80_0000, 0, 0}, 32'h7FFF_FFFF, 16'd2, 1'b1};
    vecs[4] = '{"nan_clr",1, '{32'h3F80_0000, 0, 0, 0},             32'h3F80_0000, 16'd1, 1'b0};
    vecs[5] = '{"three",  3, '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0}, 32'h40C0_0000, 16'd3, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("post_rst_add_a",     add_a, 32'd0);
    check("post_rst_add_b",     add_b, 32'd0);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_out_data",  out_data, 32'd0);
    check("post_rst_out_count", {16'd0, out_count}, 32'd0);
    check("post_rst_out_nan",   {31'd0, out_nan}, 32'd0);

    // Table-driven streams.
    for (int v = 0; v < 6; v++) begin
      for (int e = 0; e < vecs[v].n; e++) send(vecs[v].elem[e], (e == vecs[v].n - 1));
      expect_result(vecs[v].name, vecs[v].sum, vecs[v].cnt, vecs[v].nan);
    end

    // Backpressure: result held, no acceptance while in ST_OUT.
    out_ready = 1'b0;
    send(32'h3FC0_0000, 1'b0);
    send(32'h3FC0_0000, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h3F80_0000;
    in_last  = 1'b1;
    acc0     = n_acc;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid",    {31'd0, out_valid}, 32'd1);
      check("bp_data",     out_data, 32'h4040_0000);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    check("bp_no_accept", n_acc, acc0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);

    // Input gaps; also drives the 2-bit counter instance into saturation.
    acc0 = n_acc;
    for (int e = 0; e < 4; e++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(32'h3F80_0000, (e == 3));
    end
    check("gap_accepts", n_acc - acc0, 32'd4);
    check("gap_sat_valid_pre", {31'd0, out_valid2}, 32'd0);
    @(negedge clk);
    check("gap_valid", {31'd0, out_valid}, 32'd1);
    check("gap_data",  out_data, 32'h4080_0000);
    check("gap_count", {16'd0, out_count}, 32'd4);
    check("sat_count", {30'd0, out_count2}, 32'd3);
    check("sat_data",  out_data2, 32'h4080_0000);
    @(negedge clk);
    check("gap_ready_back", {31'd0, in_ready}, 32'd1);

    // Reset while in ST_SUM discards the partial accumulation.
    send(32'h4000_0000, 1'b0);
    hold = {31'd0, in_ready};
    check("mid_in_sum", hold, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_add_a", add_a, 32'd0);
    check("mid_rst_add_b", add_b, 32'd0);
    check("mid_rst_count", {16'd0, out_count}, 32'd0);
    check("mid_rst_data",  out_data, 32'd0);
    send(32'h3F80_0000, 1'b1);
    expect_result("after_rst", 32'h3F80_0000, 16'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
